// File: rtl/sdram_intf_if.sv
// User-side burst bus of the SDRAM controller: level requests, ack window,
// write data in, read data out and the init status flag.
interface sdram_intf_if;
  logic        wr_req;
  logic        rd_req;
  logic [24:0] rw_addr;
  logic [15:0] wr_data;
  logic        ack;
  logic [15:0] rd_data;
  logic        rd_data_vld;
  logic        init_done;

  modport master (
    output wr_req, rd_req, rw_addr, wr_data,
    input  ack, rd_data, rd_data_vld, init_done
  );

  modport slave (
    input  wr_req, rd_req, rw_addr, wr_data,
    output ack, rd_data, rd_data_vld, init_done
  );
endinterface

// File: rtl/sdram_intf.sv
// Full-page burst SDRAM controller: power-up init, periodic refresh, burst write/read.
// Define SDRAM_DQ_IN_REG_EN to add an input register on sdram_dq_in (read latency CL+2).
module sdram_intf #(
  parameter int BURST_LEN = 1024,
  parameter int T_INIT    = 20000,
  parameter int T_REF     = 750,
  parameter int T_RP      = 2,
  parameter int T_RFC     = 7,
  parameter int T_MRD     = 2,
  parameter int T_RCD     = 2,
  parameter int CL        = 3
) (
  input  logic        clk,
  input  logic        rst,
  sdram_intf_if.slave bus,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr,
  output logic [1:0]  sdram_dqm,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  input  logic [15:0] sdram_dq_in
);

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS, IDLE,
    REFRESH, ACTIVE, WRITE, READ, PRECH
  } state_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_MRS = 4'b0000;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_BST = 4'b0110;

  localparam logic [12:0] MODE_WORD = 13'h0037;

  localparam int CNT_W = $clog2(T_INIT + BURST_LEN + CL + 2*T_RFC + T_RP + T_MRD + T_RCD + 8);
  localparam int REF_W = $clog2(T_REF + 1);

  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RFC_LAST  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] RFC_2ND   = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] RFC2_LAST = CNT_W'(2*T_RFC - 1);
  localparam logic [CNT_W-1:0] MRD_LAST  = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] RCD_LAST  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] BL_END    = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(BURST_LEN + CL);
  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(T_REF - 1);

`ifdef SDRAM_DQ_IN_REG_EN
  localparam int VLD_LAT = CL + 2;
`else
  localparam int VLD_LAT = CL + 1;
`endif

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [REF_W-1:0]   ref_cnt;
  logic               refresh_pend;
  logic [1:0]         bank_q;
  logic [12:0]        row_q;
  logic               is_write_q;
  logic               cke_q;
  logic [15:0]        rd_data_q;
  logic [VLD_LAT-1:0] vld_pipe;

  logic [3:0]         cmd_c;
  logic [12:0]        addr_c;
  logic [1:0]         ba_c;
  logic               ack_c;
  logic               dq_oe_c;
  logic               cap_en;
  logic               cap_write;
  logic               init_done_c;
  logic               unused_col;

  // The column field is ignored: full-page bursts always start at column 0.
  assign unused_col = ^bus.rw_addr[9:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT_WAIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    next_state = state;
    cnt_next   = cnt + 1'b1;
    cmd_c      = CMD_NOP;
    addr_c     = '0;
    ba_c       = '0;
    ack_c      = 1'b0;
    dq_oe_c    = 1'b0;
    cap_en     = 1'b0;
    cap_write  = 1'b0;
    case (state)
      INIT_WAIT: begin
        if (cnt == INIT_LAST) next_state = INIT_PRE;
      end
      INIT_PRE: begin
        if (cnt == '0) begin
          cmd_c      = CMD_PRE;
          addr_c[10] = 1'b1;
        end
        if (cnt == RP_LAST) next_state = INIT_REF;
      end
      INIT_REF: begin
        if (cnt == '0 || cnt == RFC_2ND) cmd_c = CMD_REF;
        if (cnt == RFC2_LAST) next_state = INIT_MRS;
      end
      INIT_MRS: begin
        if (cnt == '0) begin
          cmd_c  = CMD_MRS;
          addr_c = MODE_WORD;
        end
        if (cnt == MRD_LAST) next_state = IDLE;
      end
      IDLE: begin
        if (refresh_pend) begin
          next_state = REFRESH;
        end else if (bus.wr_req) begin
          next_state = ACTIVE;
          cap_en     = 1'b1;
          cap_write  = 1'b1;
        end else if (bus.rd_req) begin
          next_state = ACTIVE;
          cap_en     = 1'b1;
        end
      end
      REFRESH: begin
        if (cnt == '0) cmd_c = CMD_REF;
        if (cnt == RFC_LAST) next_state = IDLE;
      end
      ACTIVE: begin
        if (cnt == '0) begin
          cmd_c  = CMD_ACT;
          ba_c   = bank_q;
          addr_c = row_q;
        end
        if (cnt == RCD_LAST) next_state = is_write_q ? WRITE : READ;
      end
      WRITE: begin
        if (cnt < BL_END) begin
          ack_c   = 1'b1;
          dq_oe_c = 1'b1;
          if (cnt == '0) begin
            cmd_c = CMD_WR;
            ba_c  = bank_q;
          end
        end else begin
          cmd_c      = CMD_BST;
          next_state = PRECH;
        end
      end
      READ: begin
        if (cnt < BL_END) begin
          ack_c = 1'b1;
          if (cnt == '0) begin
            cmd_c = CMD_RD;
            ba_c  = bank_q;
          end
        end else if (cnt == BL_END) begin
          cmd_c = CMD_BST;
        end
        if (cnt == RD_LAST) next_state = PRECH;
      end
      PRECH: begin
        if (cnt == '0) begin
          cmd_c      = CMD_PRE;
          addr_c[10] = 1'b1;
        end
        if (cnt == RP_LAST) next_state = IDLE;
      end
      default: next_state = INIT_WAIT;
    endcase
    if (next_state != state || state == IDLE) cnt_next = '0;
  end

  // Request parameters are frozen when leaving IDLE so rw_addr may change freely afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q     <= '0;
      row_q      <= '0;
      is_write_q <= 1'b0;
    end else if (cap_en) begin
      bank_q     <= bus.rw_addr[24:23];
      row_q      <= bus.rw_addr[22:10];
      is_write_q <= cap_write;
    end
  end

  // Free-running refresh interval timer; the pending flag waits for IDLE, so bursts are never cut.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt      <= '0;
      refresh_pend <= 1'b0;
    end else begin
      if (state == REFRESH && cnt == '0) refresh_pend <= 1'b0;
      if (init_done_c) begin
        if (ref_cnt == REF_LAST) begin
          ref_cnt      <= '0;
          refresh_pend <= 1'b1;
        end else begin
          ref_cnt <= ref_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cke_q <= 1'b0;
    else     cke_q <= 1'b1;
  end

  // Read data capture; the valid pipeline tracks read ack cycles through the CAS latency.
`ifdef SDRAM_DQ_IN_REG_EN
  logic [15:0] dq_in_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_in_q   <= '0;
      rd_data_q <= '0;
    end else begin
      dq_in_q   <= sdram_dq_in;
      rd_data_q <= dq_in_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= sdram_dq_in;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[VLD_LAT-2:0], (state == READ) && ack_c};
  end

  assign init_done_c = (state != INIT_WAIT) && (state != INIT_PRE) &&
                       (state != INIT_REF)  && (state != INIT_MRS);

  assign bus.ack         = ack_c;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_data_vld = vld_pipe[VLD_LAT-1];
  assign bus.init_done   = init_done_c;

  assign sdram_cke    = cke_q;
  assign sdram_cs_n   = cmd_c[3];
  assign sdram_ras_n  = cmd_c[2];
  assign sdram_cas_n  = cmd_c[1];
  assign sdram_we_n   = cmd_c[0];
  assign sdram_ba     = ba_c;
  assign sdram_addr   = addr_c;
  assign sdram_dqm    = init_done_c ? 2'b00 : 2'b11;
  assign sdram_dq_oe  = dq_oe_c;
  assign sdram_dq_out = dq_oe_c ? bus.wr_data : 16'h0000;

endmodule

// File: tb/tb_sdram_intf.sv
// Directed bench for sdram_intf: init timing, burst write/read, refresh ordering, reset abort.
module tb_sdram_intf;

  localparam logic [3:0] NOP = 4'b0111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] REF = 4'b0001;
  localparam logic [3:0] MRS = 4'b0000;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WR  = 4'b0100;
  localparam logic [3:0] RD  = 4'b0101;
  localparam logic [3:0] BST = 4'b0110;

`ifdef SDRAM_DQ_IN_REG_EN
  localparam int VLD_LAT = 5;
`else
  localparam int VLD_LAT = 4;
`endif

  localparam logic [24:0] ADDR_B1_R5 = {2'b01, 13'd5, 10'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic [15:0] sdram_dq_in;
  logic [3:0]  cmd;

  int total = 0;
  int bad   = 0;

  sdram_intf_if bus();

  sdram_intf dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .sdram_cke    (sdram_cke),
    .sdram_cs_n   (sdram_cs_n),
    .sdram_ras_n  (sdram_ras_n),
    .sdram_cas_n  (sdram_cas_n),
    .sdram_we_n   (sdram_we_n),
    .sdram_ba     (sdram_ba),
    .sdram_addr   (sdram_addr),
    .sdram_dqm    (sdram_dqm),
    .sdram_dq_out (sdram_dq_out),
    .sdram_dq_oe  (sdram_dq_oe),
    .sdram_dq_in  (sdram_dq_in)
  );

  always #5 clk = ~clk;

  assign cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [24:0] addr);
    bus.wr_req  = wr;
    bus.rd_req  = rd;
    bus.rw_addr = addr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ack"},   32'(bus.ack), 32'd0);
    checkOutput({tag, "_vld"},   32'(bus.rd_data_vld), 32'd0);
    checkOutput({tag, "_done"},  32'(bus.init_done), 32'd0);
    checkOutput({tag, "_oe"},    32'(sdram_dq_oe), 32'd0);
    checkOutput({tag, "_cke"},   32'(sdram_cke), 32'd0);
    checkOutput({tag, "_cmd"},   32'(cmd), 32'(NOP));
    checkOutput({tag, "_addr"},  32'(sdram_addr), 32'd0);
    checkOutput({tag, "_ba"},    32'(sdram_ba), 32'd0);
    checkOutput({tag, "_dqm"},   32'(sdram_dqm), 32'd3);
  endtask

  task automatic checkInitSequence(input string tag);
    step(19999);
    checkOutput({tag, "_wait_cmd"}, 32'(cmd), 32'(NOP));
    checkOutput({tag, "_wait_cke"}, 32'(sdram_cke), 32'd1);
    step(1);
    checkOutput({tag, "_pre_cmd"},  32'(cmd), 32'(PRE));
    checkOutput({tag, "_pre_a10"},  32'(sdram_addr), 32'h400);
    step(2);
    checkOutput({tag, "_ref1_cmd"}, 32'(cmd), 32'(REF));
    step(7);
    checkOutput({tag, "_ref2_cmd"}, 32'(cmd), 32'(REF));
    step(7);
    checkOutput({tag, "_mrs_cmd"},  32'(cmd), 32'(MRS));
    checkOutput({tag, "_mrs_addr"}, 32'(sdram_addr), 32'h037);
    checkOutput({tag, "_mrs_done"}, 32'(bus.init_done), 32'd0);
    step(1);
    checkOutput({tag, "_pre_done"}, 32'(bus.init_done), 32'd0);
    step(1);
    checkOutput({tag, "_done"},     32'(bus.init_done), 32'd1);
    checkOutput({tag, "_dqm"},      32'(sdram_dqm), 32'd0);
    checkOutput({tag, "_idle_cmd"}, 32'(cmd), 32'(NOP));
  endtask

  initial begin
    logic [3:0] exp_cmd;
    sdram_dq_in = '0;
    bus.wr_data = '0;
    applyStimulus(1'b0, 1'b0, '0);
    $display("[TB] power-up reset");
    step(3);
    checkResetState("reset");

    rst = 1'b0;
    checkInitSequence("init");

    // Burst write; rw_addr is scrambled after ACT to prove it was captured.
    $display("[TB] burst write");
    applyStimulus(1'b1, 1'b0, ADDR_B1_R5);
    step(1);
    checkOutput("wr_act_cmd", 32'(cmd), 32'(ACT));
    checkOutput("wr_act_ba", 32'(sdram_ba), 32'd1);
    checkOutput("wr_act_row", 32'(sdram_addr), 32'd5);
    checkOutput("wr_act_ack", 32'(bus.ack), 32'd0);
    applyStimulus(1'b1, 1'b0, 25'h1FFFFFF);
    step(1);
    checkOutput("wr_rcd_ack", 32'(bus.ack), 32'd0);
    step(1);
    for (int k = 0; k < 1024; k++) begin
      checkOutput("wr_ack", 32'(bus.ack), 32'd1);
      checkOutput("wr_oe", 32'(sdram_dq_oe), 32'd1);
      checkOutput("wr_cmd", 32'(cmd), 32'((k == 0) ? WR : NOP));
      if (k == 0) begin
        checkOutput("wr_ba", 32'(sdram_ba), 32'd1);
        checkOutput("wr_col", 32'(sdram_addr), 32'd0);
      end
      bus.wr_data = 16'($urandom);
      #1;
      checkOutput("wr_dq_out", 32'(sdram_dq_out), 32'(bus.wr_data));
      step(1);
    end
    checkOutput("wr_bst_cmd", 32'(cmd), 32'(BST));
    checkOutput("wr_bst_ack", 32'(bus.ack), 32'd0);
    checkOutput("wr_bst_oe", 32'(sdram_dq_oe), 32'd0);

    // Refresh expired mid-write: PRE, then REF ahead of the queued read.
    applyStimulus(1'b0, 1'b1, ADDR_B1_R5);
    step(1);
    checkOutput("wr_pre_cmd", 32'(cmd), 32'(PRE));
    checkOutput("wr_pre_a10", 32'(sdram_addr), 32'h400);
    step(3);
    checkOutput("late_ref_cmd", 32'(cmd), 32'(REF));
    step(8);
    $display("[TB] burst read");
    checkOutput("rd_act_cmd", 32'(cmd), 32'(ACT));
    checkOutput("rd_act_ba", 32'(sdram_ba), 32'd1);
    checkOutput("rd_act_row", 32'(sdram_addr), 32'd5);
    step(2);
    for (int s = 0; s < 1040; s++) begin
      sdram_dq_in = 16'hC000 + 16'(s);
      if (s == 0)             exp_cmd = RD;
      else if (s == 1024)     exp_cmd = BST;
      else if (s == 1028)     exp_cmd = PRE;
      else if (s == 1031)     exp_cmd = REF;
      else                    exp_cmd = NOP;
      checkOutput("rd_cmd", 32'(cmd), 32'(exp_cmd));
      checkOutput("rd_ack", 32'(bus.ack), 32'(s < 1024));
      checkOutput("rd_oe", 32'(sdram_dq_oe), 32'd0);
      checkOutput("rd_vld", 32'(bus.rd_data_vld), 32'((s >= VLD_LAT) && (s < VLD_LAT + 1024)));
      if (s >= VLD_LAT && s < VLD_LAT + 1024)
        checkOutput("rd_data", 32'(bus.rd_data), 32'h0000C003 + 32'(s - VLD_LAT));
      if (s == 0) begin
        checkOutput("rd_ba", 32'(sdram_ba), 32'd1);
        checkOutput("rd_col", 32'(sdram_addr), 32'd0);
      end
      if (s == 1024) applyStimulus(1'b0, 1'b0, ADDR_B1_R5);
      step(1);
    end

    // Write request arrives in the same IDLE cycle the refresh flag rises.
    $display("[TB] refresh collision");
    step(168);
    checkOutput("coll_idle_cmd", 32'(cmd), 32'(NOP));
    step(1);
    checkOutput("coll_idle2_cmd", 32'(cmd), 32'(NOP));
    applyStimulus(1'b1, 1'b0, ADDR_B1_R5);
    step(1);
    checkOutput("coll_ref_cmd", 32'(cmd), 32'(REF));
    step(8);
    checkOutput("coll_act_cmd", 32'(cmd), 32'(ACT));
    step(2);
    checkOutput("coll_wr_cmd", 32'(cmd), 32'(WR));
    checkOutput("coll_wr_ack", 32'(bus.ack), 32'd1);

    $display("[TB] reset mid-burst");
    step(299);
    checkOutput("abort_ack_before", 32'(bus.ack), 32'd1);
    checkOutput("abort_oe_before", 32'(sdram_dq_oe), 32'd1);
    rst = 1'b1;
    #1;
    checkResetState("abort");
    applyStimulus(1'b0, 1'b0, '0);
    step(2);
    rst = 1'b0;
    checkInitSequence("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_intf.md
SDRAM_INTF -- requirements
Module: sdram_intf

Interface
REQ-001 SHALL have parameter BURST_LEN, default 1024, words per burst (full page; column always starts at 0).
REQ-002 SHALL have parameter T_INIT, default 20000, power-up wait in clk cycles (200 us at 100 MHz).
REQ-003 SHALL have parameter T_REF, default 750, refresh interval in cycles.
REQ-004 SHALL have parameters T_RP 2, T_RFC 7, T_MRD 2, T_RCD 2, CL 3: SDRAM timing in cycles.
REQ-005 clk  in  1  single system/SDRAM clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 wr_req  in  1  level burst-write request, held until ack falls.
REQ-008 rd_req  in  1  level burst-read request, held until ack falls.
REQ-009 rw_addr  in  25  {bank[24:23], row[22:10], col[9:0]}.
REQ-010 wr_data  in  16  write word, consumed every cycle ack is high in a write.
REQ-011 ack  out  1  high exactly BURST_LEN cycles per accepted burst.
REQ-012 rd_data  out  16  read word; rd_data_vld  out  1  qualifies rd_data.
REQ-013 init_done  out  1  high once the initialisation sequence completes.
REQ-014 sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins.
REQ-015 sdram_ba  out  2; sdram_addr  out  13; sdram_dqm  out  2 (always 0 after init).
REQ-016 sdram_dq_out  out  16; sdram_dq_oe  out  1; sdram_dq_in  in  16 (tristate at top level).

Function
REQ-017 Commands {cs_n,ras_n,cas_n,we_n} SHALL be NOP 0111, PRE 0010, REF 0001, MRS 0000, ACT 0011, WR 0100, RD 0101, BST 0110; NOP in every cycle not otherwise specified.
REQ-018 States SHALL be INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS, IDLE, REFRESH, ACTIVE, WRITE, READ, PRECH.
REQ-019 INIT: wait T_INIT with cke=1 -> PRE (addr[10]=1, all banks) + T_RP -> two REF each + T_RFC -> MRS (addr=13'h0037: full page, sequential, CL3) + T_MRD -> IDLE, init_done=1.
REQ-020 Refresh counter SHALL count T_REF cycles from init_done, set refresh_pend on terminal count and auto-restart; refresh_pend is cleared when REF is issued.
REQ-021 IDLE priority: refresh_pend > wr_req > rd_req; requests are sampled only in IDLE; a burst is never interrupted by refresh.
REQ-022 REFRESH: issue REF, wait T_RFC, return to IDLE.
REQ-023 ACTIVE: issue ACT with captured bank/row, wait T_RCD, go to WRITE or READ.
REQ-024 WRITE: ack=1 and dq_oe=1 for BURST_LEN cycles, WR (col 0, addr[10]=0) on the first cycle, sdram_dq_out=wr_data combinationally each ack cycle; the next cycle issues BST with dq_oe=0.
REQ-025 READ: RD on the first of BURST_LEN ack cycles, BST on the cycle after the last ack, then wait CL cycles before PRECH.
REQ-026 rd_data_vld SHALL rise CL+1 cycles after RD and stay high exactly BURST_LEN cycles.
REQ-027 PRECH: issue PRE all banks, wait T_RP, return to IDLE; this guarantees at least T_RP cycles between ack falling and the next request sample.
REQ-028 Address, bank and request type SHALL be captured on leaving IDLE; later rw_addr changes are ignored.
REQ-029 wr_req and rd_req both high in IDLE -> write served; rd_req is served after the write if still high.

Reset
REQ-030 rst SHALL force INIT_WAIT, clear all counters and refresh_pend, and set ack=0, rd_data_vld=0, init_done=0, dq_oe=0, cke=0, command NOP, sdram_addr/ba=0, dqm=2'b11.
REQ-031 rst mid-burst SHALL abort immediately and rerun the full init sequence.

Configuration
REQ-032 Macro SDRAM_DQ_IN_REG_EN defined -> extra input register on sdram_dq_in, rd_data_vld latency CL+2; undefined -> CL+1 per REQ-026.

Verification
REQ-033 Power-up: after rst release, PRE at cycle 20000, REF at 20002 and 20009, MRS addr 0x037 at 20016, init_done at 20018.
REQ-034 Write: wr_req, rw_addr={2'b01,13'd5,10'd0} -> ACT ba=1 row=5; WR 2 cycles later; ack high 1024 cycles; BST; PRE; dq_out tracks wr_data.
REQ-035 Read: rd_req, same address -> RD; rd_data_vld rises 4 cycles later (5 with macro) for exactly 1024 cycles.
REQ-036 Refresh collision: refresh_pend and wr_req both present in IDLE -> REF issued first, ACT after T_RFC.
REQ-037 Refresh during burst: counter expires mid-write -> no REF until after PRE completes, then REF before any new request.
REQ-038 Reset at the 300th ack cycle of a write -> ack=0, dq_oe=0 immediately; init sequence restarts from INIT_WAIT.
